// File: rtl/percount.sv
// rtl/percount.sv - tap-button period counter feeding per2bpm
//
// Purpose:
//   Counts time pulses between two successive rising edges of the debounced
//   tap button. It reports the interval clamped to [BTN_PER_MIN..BTN_PER_MAX]
//   together with a one-cycle strobe. An interval longer than BTN_PER_MAX is
//   discarded, and the next press starts a new measurement.
//
// Ports:
//   clk_i          in   1          system clock, rising edge
//   rst_i          in   1          synchronous reset, active-low
//   tp_i           in   1          time pulse, one clk_i cycle per tp
//   btn_i          in   1          debounced button level, 1 = pressed
//   btn_per_o      out  PER_WIDTH  last measured period in tp
//   btn_per_valid  out  1          one-cycle strobe, btn_per_o new this cycle

module percount #(
    parameter int PER_WIDTH   = 16,
    parameter int BTN_PER_MIN = 240,
    parameter int BTN_PER_MAX = 2000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tp_i,
    input  logic                 btn_i,
    output logic [PER_WIDTH-1:0] btn_per_o,
    output logic                 btn_per_valid
);

    localparam logic [PER_WIDTH-1:0] PER_MIN = PER_WIDTH'(BTN_PER_MIN);
    localparam logic [PER_WIDTH-1:0] PER_MAX = PER_WIDTH'(BTN_PER_MAX);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PER_WIDTH-1:0]   r_cnt;
    logic [PER_WIDTH-1:0]   w_cnt_nxt;
    logic [PER_WIDTH-1:0]   r_per;
    logic [PER_WIDTH-1:0]   w_per_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_btn_old;
    logic                   w_rise;

    assign w_rise = btn_i & ~r_btn_old;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_per_nxt   = r_per;
        w_valid_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_rise) begin
                    // A press wins over a coincident tick, so the tick is dropped.
                    w_cnt_nxt   = '0;
                    w_per_nxt   = (r_cnt < PER_MIN) ? PER_MIN : r_cnt;
                    w_valid_nxt = 1'b1;
                end else if (tp_i) begin
                    // Compare before incrementing so the counter can never wrap.
                    if (r_cnt == PER_MAX) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_per     <= '0;
            r_valid   <= 1'b0;
            // Start high so that a button held through reset does not register as a press.
            r_btn_old <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_per     <= w_per_nxt;
            r_valid   <= w_valid_nxt;
            r_btn_old <= btn_i;
        end
    end

    assign btn_per_o     = r_per;
    assign btn_per_valid = r_valid;

endmodule

// File: tb/tb_percount.sv
// tb/tb_percount.sv - directed self-checking bench for percount

module tb_percount;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        tp_i;
    logic        btn_i;
    logic [15:0] btn_per_o;
    logic        btn_per_valid;

    int n_err    = 0;
    int n_checks = 0;
    int n_strobe = 0;
    logic prev_v = 1'b0;

    percount #(
        .PER_WIDTH  (16),
        .BTN_PER_MIN(240),
        .BTN_PER_MAX(2000)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tp_i         (tp_i),
        .btn_i        (btn_i),
        .btn_per_o    (btn_per_o),
        .btn_per_valid(btn_per_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there as well.
    task automatic cyc();
        @(negedge clk);
        chk("valid_back_to_back", {31'b0, prev_v & btn_per_valid}, 32'd0);
        if (btn_per_valid === 1'b1) n_strobe++;
        prev_v = btn_per_valid;
    endtask

    task automatic tps(input int n);
        for (int i = 0; i < n; i++) begin
            tp_i = 1'b1;
            cyc();
            tp_i = 1'b0;
            cyc();
        end
    endtask

    task automatic press(input string tag, input logic with_tp, input logic exp_strobe,
                         input int exp_per);
        btn_i = 1'b1;
        tp_i  = with_tp;
        cyc();
        chk({tag, "_valid"}, {31'b0, btn_per_valid}, {31'b0, exp_strobe});
        chk({tag, "_per"}, {16'b0, btn_per_o}, exp_per);
        btn_i = 1'b0;
        tp_i  = 1'b0;
        cyc();
        chk({tag, "_valid_drop"}, {31'b0, btn_per_valid}, 32'd0);
    endtask

    initial begin
        // 1: reset with the button held, then release without pressing
        rst_i = 1'b0;
        btn_i = 1'b1;
        tp_i  = 1'b0;
        repeat (3) cyc();
        chk("rst_valid", {31'b0, btn_per_valid}, 32'd0);
        chk("rst_per", {16'b0, btn_per_o}, 32'd0);
        rst_i = 1'b1;
        repeat (3) cyc();
        chk("held_btn_valid", {31'b0, btn_per_valid}, 32'd0);
        btn_i = 1'b0;
        tps(5);
        chk("t1_strobes", n_strobe, 32'd0);
        chk("t1_per", {16'b0, btn_per_o}, 32'd0);

        // 2: three presses, 500 tp apart
        press("t2_p1", 1'b0, 1'b0, 0);
        tps(500);
        press("t2_p2", 1'b0, 1'b1, 500);
        tps(500);
        press("t2_p3", 1'b0, 1'b1, 500);
        chk("t2_strobes", n_strobe, 32'd2);

        // 3: an interval shorter than the minimum is clamped
        tps(100);
        press("t3_clamp", 1'b0, 1'b1, 240);
        chk("t3_strobes", n_strobe, 32'd3);

        // 4: timeout after 2001 tp, then restart; exactly 2000 tp reports MAX
        tps(2001);
        press("t4_after_timeout", 1'b0, 1'b0, 240);
        chk("t4_no_strobe", n_strobe, 32'd3);
        tps(300);
        press("t4_300", 1'b0, 1'b1, 300);
        tps(2000);
        press("t4_max", 1'b0, 1'b1, 2000);
        chk("t4_strobes", n_strobe, 32'd5);

        // 5: press coincides with a tick; the tick is discarded
        tps(10);
        press("t5_coincident", 1'b1, 1'b1, 240);
        tps(400);
        press("t5_400", 1'b0, 1'b1, 400);
        chk("t5_strobes", n_strobe, 32'd7);

        // 6: one-cycle reset 350 tp into a count drops the interval
        tps(350);
        rst_i = 1'b0;
        cyc();
        chk("t6_rst_valid", {31'b0, btn_per_valid}, 32'd0);
        chk("t6_rst_per", {16'b0, btn_per_o}, 32'd0);
        rst_i = 1'b1;
        tps(5);
        press("t6_restart", 1'b0, 1'b0, 0);
        tps(300);
        press("t6_300", 1'b0, 1'b1, 300);
        chk("total_strobes", n_strobe, 32'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
